// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: FSM state encoding,
// retry saturation limit and the counter-sizing helper.
package pll_reset_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [3:0] RETRY_MAX = 4'd15;

  function automatic int cyc_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    cyc_max3 = (m > c) ? m : c;
  endfunction

  function automatic logic [3:0] retry_inc(input logic [3:0] cnt);
    retry_inc = (cnt == RETRY_MAX) ? RETRY_MAX : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// Two-flop level synchronizer with asynchronous active-low reset to 0,
// shared by any asynchronous status input that must enter the clk domain.
module sync_2ff
  import pll_reset_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // two-stage capture of the asynchronous level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: holds the PLL in reset, waits for a stable lock, then
// releases the system reset. Optional FAIL state: PLL_RESET_SEQ_RETRY_LIMIT_EN.
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 4096
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_locked_async,
  output logic       pll_resetb,
  output logic       sys_resetn,
  output logic       sys_ready,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
  ,
  output logic       pll_fail
`endif
);

  localparam int CNT_W = $clog2(cyc_max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE)) + 1;
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       retry_cnt_r;
  logic             retry_inc_s;
  logic             lost_s;
  logic             locked_s;
  logic             pll_resetb_r;
  logic             sys_resetn_r;
  logic             sys_ready_r;
  logic             lock_lost_r;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (pll_locked_async),
    .q     (locked_s)
  );

  // next-state decision; every decision uses the synchronized lock only
  always_comb begin
    state_nx_s  = state_r;
    retry_inc_s = 1'b0;
    lost_s      = 1'b0;
    case (state_r)
      PLL_RST: begin
        if (cnt_r == RST_LAST) begin
          state_nx_s = WAIT_LOCK;
        end else begin
          state_nx_s = PLL_RST;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nx_s = STABLE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          retry_inc_s = 1'b1;
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
          state_nx_s = (retry_cnt_r == RETRY_MAX) ? FAIL : PLL_RST;
`else
          state_nx_s = PLL_RST;
`endif
        end else begin
          state_nx_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nx_s = WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = STABLE;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nx_s = PLL_RST;
          lost_s     = 1'b1;
        end else begin
          state_nx_s = RUN;
        end
      end
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
      FAIL: begin
        state_nx_s = FAIL;
      end
`endif
      default: begin
        state_nx_s = PLL_RST;
      end
    endcase
  end

  // state, shared counter and outputs decoded from the state being entered
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= PLL_RST;
      cnt_r        <= '0;
      retry_cnt_r  <= 4'd0;
      pll_resetb_r <= 1'b0;
      sys_resetn_r <= 1'b0;
      sys_ready_r  <= 1'b0;
      lock_lost_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (state_nx_s != state_r) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (retry_inc_s) begin
        retry_cnt_r <= retry_inc(retry_cnt_r);
      end else begin
        retry_cnt_r <= retry_cnt_r;
      end
      pll_resetb_r <= (state_nx_s == WAIT_LOCK) || (state_nx_s == STABLE) || (state_nx_s == RUN);
      sys_resetn_r <= (state_nx_s == RUN);
      sys_ready_r  <= (state_nx_s == RUN);
      lock_lost_r  <= lost_s;
    end
  end

`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
  logic pll_fail_r;

  // terminal failure flag, left only through resetn
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pll_fail_r <= 1'b0;
    end else begin
      pll_fail_r <= (state_nx_s == FAIL);
    end
  end

  assign pll_fail = pll_fail_r;
`endif

  assign pll_resetb = pll_resetb_r;
  assign sys_resetn = sys_resetn_r;
  assign sys_ready  = sys_ready_r;
  assign lock_lost  = lock_lost_r;
  assign retry_cnt  = retry_cnt_r;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: each step queues the lock level to drive
// and the outputs expected after the following clock edge.
module tb_pll_reset_seq;

  localparam int PRC = 4;
  localparam int LTO = 32;
  localparam int LST = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       lock;
  logic       pll_resetb;
  logic       sys_resetn;
  logic       sys_ready;
  logic       lock_lost;
  logic [3:0] retry_cnt;
  logic       pll_fail;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       lock;
    logic [8:0] exp;
  } step_t;

  step_t sb_q[$];

  always #5 clk = ~clk;

`ifndef PLL_RESET_SEQ_RETRY_LIMIT_EN
  assign pll_fail = 1'b0;
`endif

  pll_reset_seq #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LTO),
    .LOCK_STABLE    (LST)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .pll_locked_async (lock),
    .pll_resetb       (pll_resetb),
    .sys_resetn       (sys_resetn),
    .sys_ready        (sys_ready),
    .lock_lost        (lock_lost),
    .retry_cnt        (retry_cnt)
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
    ,
    .pll_fail         (pll_fail)
`endif
  );

  // {pll_fail, pll_resetb, sys_resetn, sys_ready, lock_lost, retry_cnt}
  function automatic logic [8:0] obs();
    return {pll_fail, pll_resetb, sys_resetn, sys_ready, lock_lost, retry_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // queue n steps; rdy doubles as sys_resetn and sys_ready (both high only in RUN)
  task automatic push(input int n, input logic lk, input logic pr, input logic rdy,
                      input logic ll, input logic [3:0] rc, input logic pf);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({lk, pf, pr, rdy, rdy, ll, rc});
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    lock   = 1'b0;
    tick();
    tick();
    vectors++;
    if (obs() !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_values: got %b want %b", obs(), 9'd0);
    end
    resetn = 1'b1;
  endtask

  task automatic test_timeout();
    step_t s;
    int    n = 0;
    push(PRC - 1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    push(LTO,     1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    push(1,       1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      lock = s.lock;
      tick();
      vectors++;
      if (obs() !== s.exp) begin
        miscompares++;
        $display("FAIL timeout step %0d: got %b want %b", n, obs(), s.exp);
      end
      n++;
    end
  endtask

  task automatic test_lock_release();
    step_t s;
    int    n = 0;
    push(PRC - 1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    push(6,       1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    push(2 + LST, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    push(3,       1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      lock = s.lock;
      tick();
      vectors++;
      if (obs() !== s.exp) begin
        miscompares++;
        $display("FAIL lock_release step %0d: got %b want %b", n, obs(), s.exp);
      end
      n++;
    end
  endtask

  task automatic test_lock_loss();
    step_t s;
    int    n = 0;
    push(2,       1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0);
    push(1,       1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
    push(PRC - 1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    push(1 + LST, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    push(3,       1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      lock = s.lock;
      tick();
      vectors++;
      if (obs() !== s.exp) begin
        miscompares++;
        $display("FAIL lock_loss step %0d: got %b want %b", n, obs(), s.exp);
      end
      n++;
    end
  endtask

  // one-cycle lock drop when the stable count has reached LST-2
  task automatic test_stable_glitch();
    step_t s;
    int    n = 0;
    push(2,       1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0);
    push(1,       1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
    push(PRC - 1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
    push(1,       1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    push(LST - 1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    push(1,       1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    push(2 + LST, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    push(3,       1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      lock = s.lock;
      tick();
      vectors++;
      if (obs() !== s.exp) begin
        miscompares++;
        $display("FAIL stable_glitch step %0d: got %b want %b", n, obs(), s.exp);
      end
      n++;
    end
  endtask

  task automatic test_async_reset();
    step_t s;
    int    n = 0;
    resetn = 1'b0;
    #1;
    vectors++;
    if (obs() !== 9'd0) begin
      miscompares++;
      $display("FAIL async_reset_no_edge: got %b want %b", obs(), 9'd0);
    end
    tick();
    vectors++;
    if (obs() !== 9'd0) begin
      miscompares++;
      $display("FAIL async_reset_held: got %b want %b", obs(), 9'd0);
    end
    resetn = 1'b1;
    push(PRC - 1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    push(1 + LST, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    push(3,       1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      lock = s.lock;
      tick();
      vectors++;
      if (obs() !== s.exp) begin
        miscompares++;
        $display("FAIL async_reset_restart step %0d: got %b want %b", n, obs(), s.exp);
      end
      n++;
    end
  endtask

  task automatic test_retry_saturate();
    step_t      s;
    int         n = 0;
    logic [3:0] rc = 4'd0;
    logic       failed = 1'b0;
    logic       fail_now;
    push(2,       1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    push(1,       1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    push(PRC - 1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int t = 1; t <= 20; t++) begin
      if (failed) begin
        push(LTO + PRC, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1);
      end else begin
        push(LTO, 1'b0, 1'b1, 1'b0, 1'b0, rc, 1'b0);
        fail_now = 1'b0;
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
        fail_now = (rc == 4'd15);
`endif
        if (fail_now) begin
          failed = 1'b1;
          push(PRC, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1);
        end else begin
          if (rc != 4'd15) rc = rc + 4'd1;
          push(PRC, 1'b0, 1'b0, 1'b0, 1'b0, rc, 1'b0);
        end
      end
    end
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      lock = s.lock;
      tick();
      vectors++;
      if (obs() !== s.exp) begin
        miscompares++;
        $display("FAIL retry_saturate step %0d: got %b want %b", n, obs(), s.exp);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_lock_release();
    test_lock_loss();
    test_stable_glitch();
    test_async_reset();
    test_retry_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
